id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the ALU in the 5-stage MIPS-subset pipeline.
- Latches decoded fields and control from ID and resolves EX/MEM and MEM/WB forwarding.
- Applies the ALUSrc immediate mux and drives the ALU operand A/B and 3-bit ALU control.
- Also flags load-use hazards back to ID and supports stall and flush (bubble insertion).

Parameters:
- DW, 32, datapath width.
- RW, 5, register-address width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold all ID/EX state this cycle.
- flush_i  in  1  load a bubble instead of ID contents.
- rs_data_i  in  DW  register-file read data, rs.
- rt_data_i  in  DW  register-file read data, rt.
- imm_i  in  DW  sign-extended immediate.
- rs_addr_i, rt_addr_i, rd_addr_i  in  RW each  ID register addresses.
- alu_ctrl_i  in  3  ALU operation code from ALU control.
- alu_src_i, reg_dst_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1 each  ID control bits.
- exm_reg_write_i  in  1  EX/MEM RegWrite.
- exm_rd_i  in  RW  EX/MEM destination.
- exm_data_i  in  DW  EX/MEM ALU result.
- mwb_reg_write_i  in  1  MEM/WB RegWrite.
- mwb_rd_i  in  RW  MEM/WB destination.
- mwb_data_i  in  DW  MEM/WB write-back data.
- data1_o  out  DW  ALU operand A.
- data2_o  out  DW  ALU operand B.
- alu_ctrl_o  out  3  to ALU.
- store_data_o  out  DW  forwarded rt value for the memory stage.
- dst_o  out  RW  rd if reg_dst else rt.
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  out  1 each  control to EX/MEM.
- valid_o  out  1  stage holds a real instruction.
- hazard_o  out  1  load-use stall request to ID/PC.

Behaviour:
- Reset (async, rst_i=1):
  - All registered fields = 0; alu_ctrl register = 3'b010 (add).
  - valid_o = 0, hazard_o = 0.
  - Outputs therefore: data1_o = 0, data2_o = 0, store_data_o = 0, dst_o = 0, all control outputs 0.
- Edge update priority: flush_i > stall_i > load.
  - flush_i=1: load bubble. All control bits = 0, alu_ctrl = 3'b010, valid = 0, addresses and data = 0. This holds even if stall_i=1.
  - stall_i=1, flush_i=0: all registers hold.
  - Otherwise: all ID inputs load, and valid = 1.
- Latency: one register stage. Data, forwarding and mux paths after the register are combinational, so the ALU sees ID/EX contents in the same cycle.
- Forwarding (combinational, per operand, on registered rs/rt):
  - Select EX/MEM if exm_reg_write_i and exm_rd_i != 0 and exm_rd_i == reg addr.
  - Else select MEM/WB if mwb_reg_write_i and mwb_rd_i != 0 and mwb_rd_i == reg addr.
  - Else use the registered read data.
  - EX/MEM has priority when both match. Register $0 is never forwarded.
- Operand outputs:
  - data1_o = forwarded rs.
  - store_data_o = forwarded rt.
  - data2_o = registered imm if alu_src, else forwarded rt.
- dst_o = rd if reg_dst, else rt (registered values).
- Bubble output: data outputs equal the forwarded/zero values with all side-effect controls 0. The bubble must never write the register file or memory.
- hazard_o (combinational): valid and mem_read (registered) and dst != 0 and (dst == rs_addr_i or dst == rt_addr_i).
  - ID is expected to respond with stall of IF/ID plus flush_i=1 here next edge.
- All arithmetic is pure selection; no width changes. alu_ctrl passes through unmodified, including unused codes.

Decomposition:
- Shared package:
  - ALU control codes: AND=000, OR=001, ADD=010, SUB=110, MUL=111.
  - Forward-select encoding: FWD_REG=00, FWD_MWB=01, FWD_EXM=10.
  - DW/RW defaults.
- Sub-module forwarding_unit: purely combinational. Takes rs/rt addresses and the EX/MEM and MEM/WB write ports; produces two 2-bit selects. Instantiated once.

Test Plan:
- Reset check: assert rst_i mid-cycle with valid state loaded -> outputs go to the reset values above immediately (async); alu_ctrl_o = 010, valid_o = 0.
- Plain load: rs=3 data 0x10, rt=4 data 0x20, alu_src=0, alu_ctrl=110, no forwarding -> next cycle data1_o = 0x10, data2_o = 0x20, alu_ctrl_o = 110.
- Double forward: rs=5 with exm_rd=5/data 0xAAAA and mwb_rd=5/data 0xBBBB, both RegWrite -> data1_o = 0xAAAA. Repeat with rs=0 and exm_rd=0 -> register data, no forward.
- Immediate: alu_src=1, imm=0xFFFFFFFC, rt forwarded from MEM/WB = 7 -> data2_o = 0xFFFFFFFC, store_data_o = 7.
- Load-use: registered lw with dst=8, ID rs_addr_i=8 -> hazard_o = 1. Then flush_i=1 -> next cycle valid_o = 0, reg_write_o = 0, mem_write_o = 0, hazard_o = 0.
- Stall/flush collision: stall_i=1 holds contents for 3 cycles with the ID inputs changing -> outputs unchanged. Then stall_i=1 with flush_i=1 -> bubble loaded.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// id_ex_stage_pkg : shared widths, ALU codes and forward-select encoding
// Revision: 1.0
// ============================================================================
package id_ex_stage_pkg;

    localparam int DEF_DW = 32;
    localparam int DEF_RW = 5;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_MWB = 2'b01,
        FWD_EXM = 2'b10
    } fwd_sel_e;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_forwarding_unit.sv
`default_nettype none
// ============================================================================
// forwarding_unit : per-operand bypass select; EX/MEM beats MEM/WB, $0 never
// Revision: 1.0
// ============================================================================
module forwarding_unit
    import id_ex_stage_pkg::*;
#(
    parameter int RW = DEF_RW
) (
    input  logic [RW-1:0] rs_addr,
    input  logic [RW-1:0] rt_addr,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_rd,
    input  logic          mwb_reg_write,
    input  logic [RW-1:0] mwb_rd,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b
);

    logic w_exm_live;
    logic w_mwb_live;

    assign w_exm_live = exm_reg_write && (exm_rd != '0);
    assign w_mwb_live = mwb_reg_write && (mwb_rd != '0);

    always_comb begin
        fwd_a = FWD_REG;
        fwd_b = FWD_REG;
        if (w_exm_live && (exm_rd == rs_addr))
            fwd_a = FWD_EXM;
        else if (w_mwb_live && (mwb_rd == rs_addr))
            fwd_a = FWD_MWB;
        if (w_exm_live && (exm_rd == rt_addr))
            fwd_b = FWD_EXM;
        else if (w_mwb_live && (mwb_rd == rt_addr))
            fwd_b = FWD_MWB;
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// id_ex_stage : ID/EX pipeline register, forwarding, ALUSrc mux, load-use flag
// Revision: 1.0
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int RW = DEF_RW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic [DW-1:0] rs_data_i,
    input  logic [DW-1:0] rt_data_i,
    input  logic [DW-1:0] imm_i,
    input  logic [RW-1:0] rs_addr_i,
    input  logic [RW-1:0] rt_addr_i,
    input  logic [RW-1:0] rd_addr_i,
    input  logic [2:0]    alu_ctrl_i,
    input  logic          alu_src_i,
    input  logic          reg_dst_i,
    input  logic          reg_write_i,
    input  logic          mem_read_i,
    input  logic          mem_write_i,
    input  logic          mem_to_reg_i,
    input  logic          exm_reg_write_i,
    input  logic [RW-1:0] exm_rd_i,
    input  logic [DW-1:0] exm_data_i,
    input  logic          mwb_reg_write_i,
    input  logic [RW-1:0] mwb_rd_i,
    input  logic [DW-1:0] mwb_data_i,
    output logic [DW-1:0] data1_o,
    output logic [DW-1:0] data2_o,
    output logic [2:0]    alu_ctrl_o,
    output logic [DW-1:0] store_data_o,
    output logic [RW-1:0] dst_o,
    output logic          reg_write_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    output logic          mem_to_reg_o,
    output logic          valid_o,
    output logic          hazard_o
);

    logic [DW-1:0] r_rs_data, r_rt_data, r_imm;
    logic [RW-1:0] r_rs_addr, r_rt_addr, r_rd_addr;
    logic [2:0]    r_alu_ctrl;
    logic          r_alu_src, r_reg_dst, r_reg_write, r_mem_read;
    logic          r_mem_write, r_mem_to_reg, r_valid;

    // Flush outranks stall so a load-use bubble lands even while ID is held.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || (flush_i && !rst_i)) begin
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs_addr    <= '0;
            r_rt_addr    <= '0;
            r_rd_addr    <= '0;
            r_alu_ctrl   <= ALU_ADD;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_valid      <= 1'b0;
        end else if (!stall_i) begin
            r_rs_data    <= rs_data_i;
            r_rt_data    <= rt_data_i;
            r_imm        <= imm_i;
            r_rs_addr    <= rs_addr_i;
            r_rt_addr    <= rt_addr_i;
            r_rd_addr    <= rd_addr_i;
            r_alu_ctrl   <= alu_ctrl_i;
            r_alu_src    <= alu_src_i;
            r_reg_dst    <= reg_dst_i;
            r_reg_write  <= reg_write_i;
            r_mem_read   <= mem_read_i;
            r_mem_write  <= mem_write_i;
            r_mem_to_reg <= mem_to_reg_i;
            r_valid      <= 1'b1;
        end
    end

    logic [1:0] w_fwd_a, w_fwd_b;

    forwarding_unit #(.RW(RW)) u_fwd (
        .rs_addr       (r_rs_addr),
        .rt_addr       (r_rt_addr),
        .exm_reg_write (exm_reg_write_i),
        .exm_rd        (exm_rd_i),
        .mwb_reg_write (mwb_reg_write_i),
        .mwb_rd        (mwb_rd_i),
        .fwd_a         (w_fwd_a),
        .fwd_b         (w_fwd_b)
    );

    logic [DW-1:0] w_op_a, w_op_b;
    logic [RW-1:0] w_dst;

    always_comb begin
        w_op_a = r_rs_data;
        w_op_b = r_rt_data;
        case (w_fwd_a)
            FWD_EXM: w_op_a = exm_data_i;
            FWD_MWB: w_op_a = mwb_data_i;
            default: w_op_a = r_rs_data;
        endcase
        case (w_fwd_b)
            FWD_EXM: w_op_b = exm_data_i;
            FWD_MWB: w_op_b = mwb_data_i;
            default: w_op_b = r_rt_data;
        endcase
    end

    assign w_dst = r_reg_dst ? r_rd_addr : r_rt_addr;

    assign data1_o      = w_op_a;
    assign store_data_o = w_op_b;
    assign data2_o      = r_alu_src ? r_imm : w_op_b;
    assign alu_ctrl_o   = r_alu_ctrl;
    assign dst_o        = w_dst;
    assign reg_write_o  = r_reg_write;
    assign mem_read_o   = r_mem_read;
    assign mem_write_o  = r_mem_write;
    assign mem_to_reg_o = r_mem_to_reg;
    assign valid_o      = r_valid;

    // Load in EX whose destination is needed by the instruction now in ID.
    assign hazard_o = r_valid && r_mem_read && (w_dst != '0) &&
                      ((w_dst == rs_addr_i) || (w_dst == rt_addr_i));

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_id_ex_stage : directed scenarios plus randomized run against a stage model
// Revision: 1.0
// ============================================================================
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int OW = 3 * DW + 3 + RW + 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, stall, flush;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic [RW-1:0] rs_addr, rt_addr, rd_addr;
    logic [2:0]    alu_ctrl;
    logic          alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    logic          exm_we, mwb_we;
    logic [RW-1:0] exm_rd, mwb_rd;
    logic [DW-1:0] exm_data, mwb_data;

    logic [DW-1:0] data1, data2, store_data;
    logic [2:0]    alu_out;
    logic [RW-1:0] dst;
    logic          wr_out, rd_out, mw_out, m2r_out, valid, hazard;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .rs_data_i(rs_data), .rt_data_i(rt_data), .imm_i(imm),
        .rs_addr_i(rs_addr), .rt_addr_i(rt_addr), .rd_addr_i(rd_addr),
        .alu_ctrl_i(alu_ctrl), .alu_src_i(alu_src), .reg_dst_i(reg_dst),
        .reg_write_i(reg_write), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .mem_to_reg_i(mem_to_reg),
        .exm_reg_write_i(exm_we), .exm_rd_i(exm_rd), .exm_data_i(exm_data),
        .mwb_reg_write_i(mwb_we), .mwb_rd_i(mwb_rd), .mwb_data_i(mwb_data),
        .data1_o(data1), .data2_o(data2), .alu_ctrl_o(alu_out),
        .store_data_o(store_data), .dst_o(dst),
        .reg_write_o(wr_out), .mem_read_o(rd_out), .mem_write_o(mw_out),
        .mem_to_reg_o(m2r_out), .valid_o(valid), .hazard_o(hazard)
    );

    // The instruction the model believes occupies the stage.
    typedef struct packed {
        logic [DW-1:0] rs_data, rt_data, imm;
        logic [RW-1:0] rs, rt, rd;
        logic [2:0]    alu;
        logic          alu_src, reg_dst, wr, mr, mw, m2r, valid;
    } instr_t;

    instr_t m;
    int checks = 0;
    int errors = 0;

    function automatic instr_t empty_instr();
        instr_t e = '0;
        e.alu = 3'b010;
        return e;
    endfunction

    function automatic logic [DW-1:0] bypass(input logic [RW-1:0] a, input logic [DW-1:0] v);
        if (exm_we && exm_rd != 0 && exm_rd == a) return exm_data;
        if (mwb_we && mwb_rd != 0 && mwb_rd == a) return mwb_data;
        return v;
    endfunction

    function automatic logic [OW-1:0] expect_out();
        logic [DW-1:0] a = bypass(m.rs, m.rs_data);
        logic [DW-1:0] b = bypass(m.rt, m.rt_data);
        logic [RW-1:0] d = m.reg_dst ? m.rd : m.rt;
        logic hz = m.valid && m.mr && d != 0 && (d == rs_addr || d == rt_addr);
        return {a, (m.alu_src ? m.imm : b), m.alu, b, d, m.wr, m.mr, m.mw, m.m2r, m.valid, hz};
    endfunction

    wire [OW-1:0] actual = {data1, data2, alu_out, store_data, dst,
                            wr_out, rd_out, mw_out, m2r_out, valid, hazard};

    task automatic tick();
        instr_t nxt = m;
        if (flush) nxt = empty_instr();
        else if (!stall) begin
            nxt.rs_data = rs_data; nxt.rt_data = rt_data; nxt.imm = imm;
            nxt.rs = rs_addr; nxt.rt = rt_addr; nxt.rd = rd_addr;
            nxt.alu = alu_ctrl; nxt.alu_src = alu_src; nxt.reg_dst = reg_dst;
            nxt.wr = reg_write; nxt.mr = mem_read; nxt.mw = mem_write;
            nxt.m2r = mem_to_reg; nxt.valid = 1'b1;
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0;
        rs_data = '0; rt_data = '0; imm = '0;
        rs_addr = '0; rt_addr = '0; rd_addr = '0;
        alu_ctrl = 3'b010; alu_src = 0; reg_dst = 0;
        reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
        exm_we = 0; exm_rd = '0; exm_data = '0;
        mwb_we = 0; mwb_rd = '0; mwb_data = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        checks++;
        if (valid !== 1'b0 || alu_out !== 3'b010 || data1 !== '0 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial got valid=%b alu=%b data1=%h need 0/010/0", valid, alu_out, data1);
        end
        rs_addr = 3; rs_data = 32'h77; alu_ctrl = 3'b111; reg_write = 1; mem_write = 1;
        tick();
        checks++;
        if (valid !== 1'b1 || data1 !== 32'h77) begin
            errors++;
            $display("FAIL reset_preload got valid=%b data1=%h need 1/00000077", valid, data1);
        end
        #2 rst = 1;
        #1;
        checks++;
        if ({data1, data2, store_data, dst, alu_out, wr_out, rd_out, mw_out, m2r_out, valid, hazard}
            !== {{3*DW{1'b0}}, {RW{1'b0}}, 3'b010, 6'b0}) begin
            errors++;
            $display("FAIL reset_async got d1=%h d2=%h sd=%h dst=%h alu=%b ctl=%b%b%b%b v=%b hz=%b need zeros alu=010",
                     data1, data2, store_data, dst, alu_out, wr_out, rd_out, mw_out, m2r_out, valid, hazard);
        end
        rst = 0;
        m = empty_instr();
        clear_inputs();
    endtask

    task automatic test_plain_load();
        clear_inputs();
        rs_addr = 3; rs_data = 32'h10; rt_addr = 4; rt_data = 32'h20; alu_ctrl = 3'b110;
        tick();
        checks++;
        if (data1 !== 32'h10 || data2 !== 32'h20 || alu_out !== 3'b110 || valid !== 1'b1) begin
            errors++;
            $display("FAIL plain_load got d1=%h d2=%h alu=%b v=%b need 10/20/110/1", data1, data2, alu_out, valid);
        end
    endtask

    task automatic test_double_forward();
        clear_inputs();
        rs_addr = 5; rs_data = 32'h1234;
        tick();
        exm_we = 1; exm_rd = 5; exm_data = 32'hAAAA;
        mwb_we = 1; mwb_rd = 5; mwb_data = 32'hBBBB;
        #1;
        checks++;
        if (data1 !== 32'hAAAA) begin
            errors++;
            $display("FAIL double_forward got %h need 0000aaaa", data1);
        end
        exm_we = 0;
        #1;
        checks++;
        if (data1 !== 32'hBBBB) begin
            errors++;
            $display("FAIL mwb_forward got %h need 0000bbbb", data1);
        end
        exm_we = 1;
        rs_addr = 0; rs_data = 32'h55;
        tick();
        exm_rd = 0; mwb_rd = 0;
        #1;
        checks++;
        if (data1 !== 32'h55) begin
            errors++;
            $display("FAIL zero_reg_forward got %h need 00000055", data1);
        end
    endtask

    task automatic test_immediate();
        clear_inputs();
        alu_src = 1; imm = 32'hFFFFFFFC; rt_addr = 6; rt_data = 32'h99;
        tick();
        mwb_we = 1; mwb_rd = 6; mwb_data = 32'h7;
        #1;
        checks++;
        if (data2 !== 32'hFFFFFFFC || store_data !== 32'h7) begin
            errors++;
            $display("FAIL immediate got d2=%h sd=%h need fffffffc/00000007", data2, store_data);
        end
    endtask

    task automatic test_load_use();
        clear_inputs();
        mem_read = 1; mem_to_reg = 1; reg_write = 1; reg_dst = 0; rt_addr = 8; rd_addr = 9;
        tick();
        clear_inputs();
        rs_addr = 8;
        #1;
        checks++;
        if (hazard !== 1'b1 || dst !== 5'd8) begin
            errors++;
            $display("FAIL load_use_detect got hz=%b dst=%0d need 1/8", hazard, dst);
        end
        flush = 1; stall = 1;
        tick();
        checks++;
        if (valid !== 1'b0 || wr_out !== 1'b0 || mw_out !== 1'b0 || hazard !== 1'b0) begin
            errors++;
            $display("FAIL load_use_bubble got v=%b wr=%b mw=%b hz=%b need 0/0/0/0", valid, wr_out, mw_out, hazard);
        end
        flush = 0; stall = 0;
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        rs_addr = 10; rs_data = 32'h1111; rt_addr = 11; rt_data = 32'h2222;
        rd_addr = 12; reg_dst = 1; reg_write = 1; alu_ctrl = 3'b001;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rs_addr = RW'($urandom_range(1, 31)); rs_data = $urandom; rt_data = $urandom;
            rd_addr = RW'($urandom_range(0, 31)); alu_ctrl = 3'($urandom); mem_write = 1;
            tick();
            checks++;
            if (data1 !== 32'h1111 || data2 !== 32'h2222 || dst !== 5'd12 || alu_out !== 3'b001 || mw_out !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got d1=%h d2=%h dst=%0d alu=%b mw=%b need 1111/2222/12/001/0",
                         i, data1, data2, dst, alu_out, mw_out);
            end
        end
        flush = 1;
        tick();
        checks++;
        if (valid !== 1'b0 || alu_out !== 3'b010 || dst !== '0 || data1 !== '0 || wr_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush got v=%b alu=%b dst=%0d d1=%h wr=%b need 0/010/0/0/0", valid, alu_out, dst, data1, wr_out);
        end
        flush = 0; stall = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 6) == 0);
            rs_data = $urandom; rt_data = $urandom; imm = $urandom;
            rs_addr = RW'($urandom_range(0, 7)); rt_addr = RW'($urandom_range(0, 7));
            rd_addr = RW'($urandom_range(0, 7)); alu_ctrl = 3'($urandom);
            {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg} = 6'($urandom);
            tick();
            exm_we = 1'($urandom); exm_rd = RW'($urandom_range(0, 7)); exm_data = $urandom;
            mwb_we = 1'($urandom); mwb_rd = RW'($urandom_range(0, 7)); mwb_data = $urandom;
            rs_addr = RW'($urandom_range(0, 7)); rt_addr = RW'($urandom_range(0, 7));
            #1;
            checks++;
            if (actual !== expect_out()) begin
                errors++;
                $display("FAIL random_outputs iter %0d got %h need %h", n, actual, expect_out());
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        m = empty_instr();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_plain_load();
        test_double_forward();
        test_immediate();
        test_load_use();
        test_stall_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
